seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 25 ++
 rtl/seq_multiplier.sv | 110 +++++++++++
 tb/tb_seq_multiplier.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Request/acknowledge bus between a requester and the sequential multiplier.
interface seq_multiplier_if #(
  parameter int unsigned DW = 4
);
  logic              req;
  logic [2*DW-1:0]   req_data;
  logic              ack;
  logic [2*DW-1:0]   ack_data;

  // Requester side: drives operands, receives the product.
  modport master (
    output req,
    output req_data,
    input  ack,
    input  ack_data
  );

  // Multiplier side: consumes operands, returns the product.
  modport slave (
    input  req,
    input  req_data,
    output ack,
    output ack_data
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier built on repeated addition.
// A request {op1, op2} is captured in IDLE. ADD then accumulates the addend
// once per cycle until the counter runs out. DONE hands the accumulator to a
// registered output stage, so ack appears one edge after the DONE cycle.
// Optional feature macro: SEQ_MUL_MIN_OP_EN. When it is defined, the smaller
// operand is loaded into the counter, which shortens latency to min(op1,op2)+2.
module seq_multiplier #(
  parameter int unsigned DW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus
);

  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  addend_q, addend_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  ack_data_q, ack_data_d;
  logic           ack_q, ack_d;

  logic [DW-1:0]  op1_c;
  logic [DW-1:0]  op2_c;

  // Split the request payload into its two unsigned operands.
  assign op1_c = bus.req_data[PW-1:DW];
  assign op2_c = bus.req_data[DW-1:0];

  // Next-state and datapath updates; every register holds unless told otherwise.
  always_comb begin
    state_d    = state_q;
    addend_d   = addend_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ack_data_d = ack_data_q;
    ack_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
`ifdef SEQ_MUL_MIN_OP_EN
          if (op1_c < op2_c) begin
            cnt_d    = op1_c;
            addend_d = op2_c;
          end else begin
            cnt_d    = op2_c;
            addend_d = op1_c;
          end
`else
          cnt_d    = op2_c;
          addend_d = op1_c;
`endif
          acc_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        if (cnt_q != '0) begin
          acc_d = acc_q + PW'(addend_q);
          cnt_d = cnt_q - DW'(1);
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        // The output stage latches the result here, so ack rises as FSM re-enters IDLE.
        ack_d      = 1'b1;
        ack_data_d = acc_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      addend_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ack_data_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addend_q   <= addend_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ack_data_q <= ack_data_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.ack_data = ack_data_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus randomized operands
// compared against plain arithmetic products and latencies.
module tb_seq_multiplier;

  localparam int unsigned DW  = 4;
  localparam int unsigned PW  = 2 * DW;
  localparam int unsigned TMO = (1 << DW) + 8;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] last_prod;

  seq_multiplier_if #(.DW(DW)) bus ();

  seq_multiplier #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected number of edges from the accepting edge to the ack cycle.
  function automatic int exp_latency(input int a, input int b);
`ifdef SEQ_MUL_MIN_OP_EN
    return ((a < b) ? a : b) + 2;
`else
    return b + 2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; DUT must be able to sample it in IDLE at the next edge.
  task automatic issue(input int a, input int b, input bit keep);
    int lat;
    bit seen;
    bus.req      = 1'b1;
    bus.req_data = {DW'(a), DW'(b)};
    tick();
    check("ack_after_accept", 32'(bus.ack), 32'(0));
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= int'(TMO); k++) begin
      tick();
      if (bus.ack) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(seen), 32'(1));
    check("latency", 32'(lat), 32'(exp_latency(a, b)));
    check("product", 32'(bus.ack_data), 32'(a * b));
    last_prod = PW'(a * b);
    if (!keep) begin
      bus.req      = 1'b0;
      bus.req_data = PW'($urandom);
    end
  endtask

  // Idle cycles: no ack, last product held.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_no_ack", 32'(bus.ack), 32'(0));
      check("ack_data_hold", 32'(bus.ack_data), 32'(last_prod));
    end
  endtask

  initial begin
    bus.req      = 1'b0;
    bus.req_data = '0;
    rst_n        = 1'b1;
    tick();
    tick();
    check("reset_ack", 32'(bus.ack), 32'(0));
    check("reset_ack_data", 32'(bus.ack_data), 32'(0));
    rst_n     = 1'b0;
    last_prod = '0;

    issue(2, 3, 1'b0);
    idle_cycles(3);

    issue(0, 0, 1'b0);
    idle_cycles(2);
    issue(2, 0, 1'b0);
    idle_cycles(2);
    issue(0, 4, 1'b0);
    idle_cycles(2);

    issue(5, 2, 1'b1);
    issue(7, 3, 1'b1);
    issue(9, 0, 1'b1);
    issue(9, 1, 1'b0);
    idle_cycles(3);

    issue(15, 15, 1'b0);
    idle_cycles(2);

    // Abort {4,5} in the middle of ADD.
    bus.req      = 1'b1;
    bus.req_data = {DW'(4), DW'(5)};
    tick();
    tick();
    tick();
    rst_n        = 1'b1;
    bus.req      = 1'b0;
    tick();
    rst_n        = 1'b0;
    check("abort_ack", 32'(bus.ack), 32'(0));
    check("abort_ack_data", 32'(bus.ack_data), 32'(0));
    last_prod = '0;
    issue(3, 4, 1'b0);
    idle_cycles(5);

    for (int i = 0; i < 1000; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << DW) - 1));
      b = int'($urandom_range(0, (1 << DW) - 1));
      issue(a, b, 1'b0);
      idle_cycles(int'($urandom_range(5, 10)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
